tdm_demux8: RTL and testbench

- 1-to-8 time-division demultiplexer: receives a serial slot stream (8 slots per frame, slot 0 marked by a frame-sync strobe) and rebuilds the 8 slots into one parallel frame word.
- Receive end of the 8-slot TDM link whose transmit side is our 8:1 mux with a 3-bit slot select.
- Delivers completed frames over a valid/ready handshake.
- Flags sync errors and overruns.

---
 rtl/tdm_demux8_pkg.sv | 23 ++
 rtl/tdm_demux8_if.sv | 43 ++++
 rtl/tdm_demux8_slot_counter.sv | 54 +++++
 rtl/tdm_demux8.sv | 138 +++++++++++++
 tb/tb_tdm_demux8.sv | 187 ++++++++++++++++++
 5 files changed

// File: rtl/tdm_demux8_pkg.sv
// tdm_demux8 shared constants and state encoding.
// TDM_PARITY_EN adds a ninth parity beat to every frame.
package tdm_pkg;

  localparam int NSLOTS = 8;
  localparam int SLOT_IDX_W = 3;

`ifdef TDM_PARITY_EN
  localparam int FRAME_LEN = NSLOTS + 1;
`else
  localparam int FRAME_LEN = NSLOTS;
`endif

  // One extra index bit once the parity beat is counted.
  localparam int CNT_W =
    (FRAME_LEN > NSLOTS) ? SLOT_IDX_W + 1 : SLOT_IDX_W;

  typedef enum logic {
    HUNT = 1'b0,
    RUN  = 1'b1
  } state_e;

endpackage

// File: rtl/tdm_demux8_if.sv
// Slot-stream input and frame-output bundle for tdm_demux8.
// Under TDM_PARITY_EN the bundle also carries par_err.
interface tdm_demux8_if #(
  parameter int SLOT_W = 1
);
  import tdm_pkg::*;

  logic [SLOT_W-1:0]        din;
  logic                     din_valid;
  logic                     frame_sync;
  logic [NSLOTS*SLOT_W-1:0] q;
  logic                     frame_valid;
  logic                     frame_ready;
  logic [CNT_W-1:0]         slot_idx;
  logic                     sync_err;
  logic                     overrun;
`ifdef TDM_PARITY_EN
  logic                     par_err;

  modport slave (
    input  din, din_valid, frame_sync, frame_ready,
    output q, frame_valid, slot_idx, sync_err, overrun,
    output par_err
  );

  modport master (
    output din, din_valid, frame_sync, frame_ready,
    input  q, frame_valid, slot_idx, sync_err, overrun,
    input  par_err
  );
`else
  modport slave (
    input  din, din_valid, frame_sync, frame_ready,
    output q, frame_valid, slot_idx, sync_err, overrun
  );

  modport master (
    output din, din_valid, frame_sync, frame_ready,
    input  q, frame_valid, slot_idx, sync_err, overrun
  );
`endif

endinterface

// File: rtl/tdm_demux8_slot_counter.sv
// Slot index tracker for tdm_demux8.
// Wraps at FRAME_LEN, reloads to 1 on sync, strobes completion.
module tdm_slot_counter #(
  parameter int FRAME_LEN = 8,
  parameter int W         = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         beat_i,
  input  logic         sync_i,
  input  logic         run_i,
  output logic [W-1:0] idx_o,
  output logic         done_o,
  output logic         resync_o
);

  localparam logic [W-1:0] LAST = W'(FRAME_LEN - 1);

  logic [W-1:0] idx_q, idx_d;
  logic         done_q, done_d;
  logic         accept;

  assign accept   = beat_i & (run_i | sync_i);
  assign resync_o = beat_i & run_i & sync_i & (idx_q != '0);

  always_comb begin
    idx_d  = idx_q;
    done_d = 1'b0;
    if (accept) begin
      unique case (1'b1)
        sync_i: idx_d = W'(1);
        (!sync_i && idx_q == LAST): begin
          idx_d  = '0;
          done_d = 1'b1;
        end
        default: idx_d = idx_q + 1'b1;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idx_q  <= '0;
      done_q <= 1'b0;
    end else begin
      idx_q  <= idx_d;
      done_q <= done_d;
    end
  end

  assign idx_o  = idx_q;
  assign done_o = done_q;

endmodule

// File: rtl/tdm_demux8.sv
// 1-to-8 TDM demultiplexer with valid/ready frame output.
// TDM_PARITY_EN: 9-beat frames with a parity check on delivery.
module tdm_demux8
  import tdm_pkg::*;
#(
  parameter int SLOT_W = 1
) (
  input logic          clk,
  input logic          rst_n,
  tdm_demux8_if.slave  bus
);

  localparam int FW = NSLOTS * SLOT_W;

  state_e           state_q, state_d;
  logic [FW-1:0]    shadow_q, shadow_d;
  logic [FW-1:0]    q_q, q_d;
  logic             fv_q, fv_d;
  logic             serr_q;
  logic             ovr_q, ovr_d;
  logic [CNT_W-1:0] idx;
  logic             done;
  logic             resync;
  logic             accept;
  logic             is_par;

  assign accept = bus.din_valid &
                  ((state_q == RUN) | bus.frame_sync);

  tdm_slot_counter #(
    .FRAME_LEN (FRAME_LEN),
    .W         (CNT_W)
  ) u_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .beat_i   (bus.din_valid),
    .sync_i   (bus.frame_sync),
    .run_i    (state_q == RUN),
    .idx_o    (idx),
    .done_o   (done),
    .resync_o (resync)
  );

`ifdef TDM_PARITY_EN
  logic [SLOT_W-1:0] par_q, par_d;
  logic              perr_q, perr_d;
  logic [SLOT_W-1:0] acc;

  assign is_par = (idx == CNT_W'(NSLOTS));

  always_comb begin
    acc = par_q;
    for (int k = 0; k < NSLOTS; k++)
      acc = acc ^ shadow_q[k*SLOT_W +: SLOT_W];
  end

  always_comb begin
    par_d = par_q;
    if (accept && !bus.frame_sync && is_par)
      par_d = bus.din;
  end
`else
  assign is_par = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    shadow_d = shadow_q;
    if (bus.din_valid && bus.frame_sync)
      state_d = RUN;
    // A sync beat always restarts the frame from a clean shadow.
    if (accept) begin
      if (bus.frame_sync) begin
        shadow_d = '0;
        shadow_d[0 +: SLOT_W] = bus.din;
      end else if (!is_par) begin
        shadow_d[int'(idx)*SLOT_W +: SLOT_W] = bus.din;
      end
    end
  end

  always_comb begin
    q_d   = q_q;
    fv_d  = fv_q;
    ovr_d = ovr_q;
`ifdef TDM_PARITY_EN
    perr_d = perr_q;
`endif
    unique case (1'b1)
      (done && (!fv_q || bus.frame_ready)): begin
        q_d  = shadow_q;
        fv_d = 1'b1;
`ifdef TDM_PARITY_EN
        perr_d = (acc != '0);
`endif
      end
      (done && fv_q && !bus.frame_ready): ovr_d = 1'b1;
      (!done && bus.frame_ready):         fv_d  = 1'b0;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= HUNT;
      shadow_q <= '0;
      q_q      <= '0;
      fv_q     <= 1'b0;
      serr_q   <= 1'b0;
      ovr_q    <= 1'b0;
`ifdef TDM_PARITY_EN
      par_q    <= '0;
      perr_q   <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      shadow_q <= shadow_d;
      q_q      <= q_d;
      fv_q     <= fv_d;
      serr_q   <= resync;
      ovr_q    <= ovr_d;
`ifdef TDM_PARITY_EN
      par_q    <= par_d;
      perr_q   <= perr_d;
`endif
    end
  end

  assign bus.q           = q_q;
  assign bus.frame_valid = fv_q;
  assign bus.slot_idx    = idx;
  assign bus.sync_err    = serr_q;
  assign bus.overrun     = ovr_q;
`ifdef TDM_PARITY_EN
  assign bus.par_err     = perr_q;
`endif

endmodule

// File: tb/tb_tdm_demux8.sv
// Directed bench for tdm_demux8 (SLOT_W=1).
// Define TDM_PARITY_EN to exercise the parity build.
module tb_tdm_demux8;
  import tdm_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  tdm_demux8_if #(.SLOT_W(1)) bus ();

  tdm_demux8 #(.SLOT_W(1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic chk(string tag, logic [31:0] obs,
                     logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs, then sit just after the edge.
  task automatic step(logic v, logic d, logic s);
    bus.din_valid  = v;
    bus.din        = d;
    bus.frame_sync = s;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 1'b0);
  endtask

  task automatic send(logic [7:0] w, int gap);
    for (int k = 0; k < FRAME_LEN; k++) begin
      if (k < NSLOTS)
        step(1'b1, w[k], k == 0);
      else
        step(1'b1, ^w, 1'b0);
      if (k != FRAME_LEN - 1)
        repeat (gap) idle();
    end
  endtask

  logic [7:0] w;

  initial begin
    rst_n           = 1'b0;
    bus.din_valid   = 1'b0;
    bus.din         = 1'b0;
    bus.frame_sync  = 1'b0;
    bus.frame_ready = 1'b1;
    @(posedge clk);
    #1;
    idle();
    chk("rst_q", bus.q, 8'h00);
    chk("rst_fv", bus.frame_valid, 0);
    chk("rst_idx", bus.slot_idx, 0);
    chk("rst_serr", bus.sync_err, 0);
    chk("rst_ovr", bus.overrun, 0);
    rst_n = 1'b1;

    step(1, 1, 0);
    step(1, 0, 0);
    step(1, 1, 0);
    chk("hunt_idx", bus.slot_idx, 0);
    chk("hunt_fv", bus.frame_valid, 0);

    w = 8'b0100_1101;
    step(1, w[0], 1);
    chk("sync_idx", bus.slot_idx, 1);
    for (int k = 1; k < NSLOTS; k++) step(1, w[k], 0);
`ifdef TDM_PARITY_EN
    step(1, ^w, 0);
`endif
    chk("f1_lat0", bus.frame_valid, 0);
    idle();
    chk("f1_fv", bus.frame_valid, 1);
    chk("f1_q", bus.q, 8'h4D);
    chk("f1_serr", bus.sync_err, 0);
`ifdef TDM_PARITY_EN
    chk("f1_perr", bus.par_err, 0);
`endif
    idle();
    chk("f1_taken", bus.frame_valid, 0);

    step(1, 1, 1);
    step(1, 1, 0);
    step(1, 1, 0);
    step(1, 0, 1);
    chk("rs_serr", bus.sync_err, 1);
    chk("rs_idx", bus.slot_idx, 1);
    w = 8'h82;
    step(1, w[1], 0);
    chk("rs_pulse", bus.sync_err, 0);
    for (int k = 2; k < NSLOTS; k++) step(1, w[k], 0);
`ifdef TDM_PARITY_EN
    step(1, ^w, 0);
`endif
    chk("rs_lat0", bus.frame_valid, 0);
    idle();
    chk("rs_fv", bus.frame_valid, 1);
    chk("rs_q", bus.q, 8'h82);
    idle();

    bus.frame_ready = 1'b0;
    send(8'h11, 0);
    idle();
    chk("hs_fv", bus.frame_valid, 1);
    chk("hs_q1", bus.q, 8'h11);
    send(8'h22, 0);
    chk("hs_hold", bus.q, 8'h11);
    bus.frame_ready = 1'b1;
    idle();
    chk("hs_q2", bus.q, 8'h22);
    chk("hs_fv2", bus.frame_valid, 1);
    chk("hs_ovr", bus.overrun, 0);
    idle();
    chk("hs_clr", bus.frame_valid, 0);

    send(8'h4D, 2);
    chk("gap_lat0", bus.frame_valid, 0);
    idle();
    chk("gap_fv", bus.frame_valid, 1);
    chk("gap_q", bus.q, 8'h4D);
    idle();

    bus.frame_ready = 1'b0;
    send(8'hA5, 0);
    idle();
    chk("bp_q1", bus.q, 8'hA5);
    chk("bp_ovr0", bus.overrun, 0);
    send(8'h3C, 0);
    idle();
    chk("bp_q", bus.q, 8'hA5);
    chk("bp_fv", bus.frame_valid, 1);
    chk("bp_ovr", bus.overrun, 1);
    bus.frame_ready = 1'b1;
    idle();
    chk("bp_drain", bus.frame_valid, 0);
    chk("bp_sticky", bus.overrun, 1);

`ifdef TDM_PARITY_EN
    w = 8'h0F;
    step(1, w[0], 1);
    for (int k = 1; k < NSLOTS; k++) step(1, w[k], 0);
    step(1, ~(^w), 0);
    idle();
    chk("par_fv", bus.frame_valid, 1);
    chk("par_err", bus.par_err, 1);
    chk("par_q", bus.q, 8'h0F);
    idle();
`endif

    bus.frame_ready = 1'b0;
    send(8'h5A, 0);
    idle();
    chk("mr_fv", bus.frame_valid, 1);
    step(1, 1, 1);
    repeat (4) step(1, 0, 0);
    chk("mr_idx5", bus.slot_idx, 5);
    rst_n = 1'b0;
    idle();
    chk("mr_q", bus.q, 8'h00);
    chk("mr_fv0", bus.frame_valid, 0);
    chk("mr_idx", bus.slot_idx, 0);
    chk("mr_ovr", bus.overrun, 0);
    chk("mr_serr", bus.sync_err, 0);
    rst_n = 1'b1;
    step(1, 1, 0);
    chk("mr_hunt", bus.slot_idx, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
